// File: rtl/cpu_oam_dma_ctrl_if.sv
// CPU-side and memory-bus-side signals of the sprite DMA controller.
// slave: the controller's view; master: the CPU core plus memory decode around it.
interface cpu_oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_stall;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic [7:0]  data_lat;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  bus_rdata,
    output cpu_stall, dma_active,
    output bus_addr, bus_wdata, bus_we, bus_re,
    output data_lat
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output bus_rdata,
    input  cpu_stall, dma_active,
    input  bus_addr, bus_wdata, bus_we, bus_re,
    input  data_lat
  );
endinterface

// File: rtl/cpu_oam_dma_ctrl.sv
// Sprite OAM DMA controller and CPU bus owner: passes the CPU bus through when
// idle, stalls the CPU and copies one 256-byte page to $2004 after a $4014 write.
// Ports: clk, rst (sync, active low), io (slave view of cpu_oam_dma_ctrl_if).
module cpu_oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input logic               clk,
  input logic               rst,
  cpu_oam_dma_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state;
  logic [7:0] idx;
  logic [7:0] page;
  logic       cyc_par;
  logic [7:0] data_lat;
  logic       stall_q;
  logic       active_q;

  logic trig;
  assign trig = io.cpu_we && (io.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= 8'h00;
      page     <= 8'h00;
      cyc_par  <= 1'b0;
      data_lat <= 8'h00;
      stall_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cyc_par <= ~cyc_par;
      case (state)
        IDLE: begin
          if (trig) begin
            page     <= io.cpu_wdata;
            state    <= HALT;
            stall_q  <= 1'b1;
            active_q <= 1'b1;
          end
        end
        // An odd halt cycle lands the first read on a get cycle
        // only after one extra alignment cycle.
        HALT: state <= cyc_par ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: state <= WRITE;
        WRITE: begin
          data_lat <= io.bus_rdata;
          if (idx == LAST_IDX) begin
            idx      <= 8'h00;
            state    <= IDLE;
            stall_q  <= 1'b0;
            active_q <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: begin
          state    <= IDLE;
          stall_q  <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.cpu_stall  = stall_q;
  assign io.dma_active = active_q;
  assign io.data_lat   = data_lat;

  // Source address is {page, idx}: idx wraps inside the page, no carry.
  always_comb begin
    io.bus_addr  = io.cpu_addr;
    io.bus_wdata = io.cpu_wdata;
    io.bus_we    = io.cpu_we;
    io.bus_re    = io.cpu_re;
    case (state)
      IDLE: ;
      READ: begin
        io.bus_addr  = {page, idx};
        io.bus_wdata = 8'h00;
        io.bus_we    = 1'b0;
        io.bus_re    = 1'b1;
      end
      WRITE: begin
        io.bus_addr  = OAM_DATA_ADDR;
        io.bus_wdata = io.bus_rdata;
        io.bus_we    = 1'b1;
        io.bus_re    = 1'b0;
      end
      default: begin
        io.bus_addr  = {page, idx};
        io.bus_wdata = 8'h00;
        io.bus_we    = 1'b0;
        io.bus_re    = 1'b0;
      end
    endcase
    if (!rst) begin
      io.bus_we = 1'b0;
      io.bus_re = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_oam_dma_ctrl.sv
// Self-checking bench for cpu_oam_dma_ctrl: passthrough vectors, even/odd DMA,
// reset mid-transfer and back-to-back transfers with a page-$FF wrap.
module tb_cpu_oam_dma_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_oam_dma_ctrl_if ifc ();

  cpu_oam_dma_ctrl dut (
    .clk(clk),
    .rst(rst),
    .io (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Expected CPU get/put parity of the current cycle.
  logic par_m = 1'b0;
  always @(posedge clk) par_m <= rst ? ~par_m : 1'b0;

  function automatic logic [7:0] memf(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return 8'(lo * 8'd3) ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous memory: data valid the cycle after bus_re.
  initial ifc.bus_rdata = 8'h00;
  always @(posedge clk)
    if (ifc.bus_re) ifc.bus_rdata <= memf(ifc.bus_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cpu_idle();
    ifc.cpu_addr  = 16'h0000;
    ifc.cpu_wdata = 8'h00;
    ifc.cpu_we    = 1'b0;
    ifc.cpu_re    = 1'b0;
  endtask

  task automatic cpu_junk();
    ifc.cpu_addr  = 16'h4014;
    ifc.cpu_wdata = 8'hEE;
    ifc.cpu_we    = 1'b1;
    ifc.cpu_re    = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_we;
    logic        e_re;
  } vec_t;

  vec_t vt[6];

  task automatic run_vectors();
    foreach (vt[i]) begin
      @(negedge clk);
      ifc.cpu_addr  = vt[i].addr;
      ifc.cpu_wdata = vt[i].wdata;
      ifc.cpu_we    = vt[i].we;
      ifc.cpu_re    = vt[i].re;
      #1;
      chk($sformatf("pass_bus[%0d]", i),
          {6'd0, ifc.bus_addr, ifc.bus_wdata, ifc.bus_we, ifc.bus_re},
          {6'd0, vt[i].e_addr, vt[i].e_wdata, vt[i].e_we, vt[i].e_re});
      chk($sformatf("pass_stall[%0d]", i), 32'(ifc.cpu_stall), 32'd0);
      @(negedge clk);
      chk($sformatf("no_trig[%0d]", i),
          32'({ifc.cpu_stall, ifc.dma_active}), 32'd0);
      cpu_idle();
    end
  endtask

  // want_odd: 0/1 waits for that halt-cycle parity, -1 triggers at once.
  task automatic run_dma(input logic [7:0] pg, input int want_odd);
    logic odd;
    logic done;
    int   stall_n, pre_n, rd_n, wr_n, act_bad;
    if (want_odd >= 0)
      while (par_m == want_odd[0]) @(negedge clk);
    odd = ~par_m;
    ifc.cpu_addr  = 16'h4014;
    ifc.cpu_wdata = pg;
    ifc.cpu_we    = 1'b1;
    ifc.cpu_re    = 1'b0;
    #1;
    chk("trig_pass", {7'd0, ifc.bus_we, ifc.bus_addr, ifc.bus_wdata},
        {7'd0, 1'b1, 16'h4014, pg});
    chk("trig_stall", 32'(ifc.cpu_stall), 32'd0);
    stall_n = 0; pre_n = 0; rd_n = 0; wr_n = 0; act_bad = 0; done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (!ifc.cpu_stall) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (ifc.dma_active !== 1'b1) act_bad++;
        if (ifc.bus_re && ifc.bus_we) act_bad++;
        if (!ifc.bus_re && !ifc.bus_we && rd_n == 0) pre_n++;
        if (ifc.bus_re) begin
          chk($sformatf("rd_addr[%02h:%0d]", pg, rd_n),
              32'(ifc.bus_addr), 32'({pg, 8'(rd_n)}));
          rd_n++;
        end
        if (ifc.bus_we) begin
          chk($sformatf("wr[%02h:%0d]", pg, wr_n),
              {8'd0, ifc.bus_addr, ifc.bus_wdata},
              {8'd0, 16'h2004, memf({pg, 8'(wr_n)})});
          wr_n++;
        end
        cpu_junk();
      end
    end
    cpu_idle();
    chk("dma_done", 32'(done), 32'd1);
    chk("stall_len", 32'(stall_n), 32'(513 + int'(odd)));
    chk("pre_read", 32'(pre_n), 32'(1 + int'(odd)));
    chk("reads", 32'(rd_n), 32'd256);
    chk("writes", 32'(wr_n), 32'd256);
    chk("active_bad", 32'(act_bad), 32'd0);
    chk("rel_active", 32'(ifc.dma_active), 32'd0);
  endtask

  task automatic run_reset_mid();
    logic found;
    int   wr_n, st_n;
    while (par_m == 1'b1) @(negedge clk);
    ifc.cpu_addr  = 16'h4014;
    ifc.cpu_wdata = 8'h04;
    ifc.cpu_we    = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      cpu_junk();
      if (ifc.bus_re && ifc.bus_addr == 16'h0440) found = 1'b1;
    end
    chk("rst_found_idx40", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_strobes", 32'({ifc.bus_we, ifc.bus_re}), 32'd0);
    @(negedge clk);
    chk("rst_release", 32'({ifc.cpu_stall, ifc.dma_active}), 32'd0);
    rst = 1'b1;
    cpu_idle();
    wr_n = 0; st_n = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (ifc.bus_we && ifc.bus_addr == 16'h2004) wr_n++;
      if (ifc.cpu_stall) st_n++;
    end
    chk("rst_no_oam_wr", 32'(wr_n), 32'd0);
    chk("rst_no_stall", 32'(st_n), 32'd0);
    ifc.cpu_addr  = 16'h0123;
    ifc.cpu_wdata = 8'h55;
    ifc.cpu_we    = 1'b1;
    #1;
    chk("rst_pass", {7'd0, ifc.bus_we, ifc.bus_addr, ifc.bus_wdata},
        {7'd0, 1'b1, 16'h0123, 8'h55});
    @(negedge clk);
    cpu_idle();
  endtask

  initial begin
    vt[0] = '{16'h0123, 8'h55, 1'b1, 1'b0, 16'h0123, 8'h55, 1'b1, 1'b0};
    vt[1] = '{16'h4016, 8'h00, 1'b0, 1'b1, 16'h4016, 8'h00, 1'b0, 1'b1};
    vt[2] = '{16'h4015, 8'h0F, 1'b1, 1'b0, 16'h4015, 8'h0F, 1'b1, 1'b0};
    vt[3] = '{16'h4013, 8'h11, 1'b1, 1'b0, 16'h4013, 8'h11, 1'b1, 1'b0};
    vt[4] = '{16'h2002, 8'hA0, 1'b0, 1'b1, 16'h2002, 8'hA0, 1'b0, 1'b1};
    vt[5] = '{16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};

    cpu_junk();
    repeat (3) @(negedge clk);
    chk("rst_state", 32'({ifc.cpu_stall, ifc.dma_active}), 32'd0);
    chk("rst_mask", 32'({ifc.bus_we, ifc.bus_re}), 32'd0);
    rst = 1'b1;
    cpu_idle();
    @(negedge clk);

    run_vectors();
    run_dma(8'h02, 0);
    @(negedge clk);
    run_dma(8'h07, 1);
    @(negedge clk);
    run_reset_mid();
    run_dma(8'hFF, 0);
    run_dma(8'h03, -1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
